segmented_pipelined_addsub: RTL

- Parametrised successor to the fully pipelined adder.
- Splits a WIDTH-bit add/subtract into CHUNK-bit ripple segments, with one pipeline register stage per segment.
- Adds a per-transaction add/subtract mode, valid tagging, a global stall enable, signed-overflow detection and synchronous reset.
- Used as the arithmetic pipe feeding datapath blocks that accept one operand pair per clock.

---
 rtl/segmented_pipelined_addsub_if.sv | 26 ++
 rtl/segmented_pipelined_addsub.sv | 112 +++++++++++
 2 files changed

// File: rtl/segmented_pipelined_addsub_if.sv
// Operand/result bundle for segmented_pipelined_addsub.
// Valid-only stream with no backpressure: one transaction per edge where en=1 and in_valid=1; en=0 freezes everything.
interface segmented_pipelined_addsub_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             in_valid;
   logic             sub;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic [WIDTH-1:0] s;
   logic             cout;
   logic             ovf;

   modport master (
      output en, in_valid, sub, a, b, cin,
      input  out_valid, s, cout, ovf
   );

   modport slave (
      input  en, in_valid, sub, a, b, cin,
      output out_valid, s, cout, ovf
   );
endinterface

// File: rtl/segmented_pipelined_addsub.sv
// WIDTH-bit add/subtract split into CHUNK-bit ripple segments, one register stage per segment.
// Operands skew in, results de-skew out, so a transaction's full result appears STAGES enabled edges after acceptance.
module segmented_pipelined_addsub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 3
) (
   input logic                         clk,
   input logic                         rst,
   segmented_pipelined_addsub_if.slave bus
);
   localparam int STAGES = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int TOPW   = WIDTH - (STAGES - 1) * CHUNK;

   // Subtraction folds into addition here, so the mode never needs to travel down the pipe.
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;
   assign b_eff   = bus.sub ? ~bus.b : bus.b;
   assign cin_eff = bus.cin ^ bus.sub;

   wire [STAGES-1:0] carry_w;
   wire [WIDTH-1:0]  s_w;
   wire              ovf_w;
   logic [STAGES-1:0] v_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
      end else if (bus.en) begin
         v_q[0] <= bus.in_valid;
         for (int i = 1; i < STAGES; i++) v_q[i] <= v_q[i-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      localparam int LO = k * CHUNK;
      localparam int CW = (k == STAGES - 1) ? TOPW : CHUNK;

      logic [CW-1:0] a_seg;
      logic [CW-1:0] b_seg;
      logic          c_in;
      logic [CW:0]   sum;
      logic          carry_q;
      logic [CW-1:0] r_dl [STAGES-k];

      if (k == 0) begin : g_head
         assign a_seg = bus.a[LO +: CW];
         assign b_seg = b_eff[LO +: CW];
         assign c_in  = cin_eff;
      end else begin : g_body
         logic [CW-1:0] a_dl [k];
         logic [CW-1:0] b_dl [k];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int i = 0; i < k; i++) begin
                  a_dl[i] <= '0;
                  b_dl[i] <= '0;
               end
            end else if (bus.en) begin
               a_dl[0] <= bus.a[LO +: CW];
               b_dl[0] <= b_eff[LO +: CW];
               for (int i = 1; i < k; i++) begin
                  a_dl[i] <= a_dl[i-1];
                  b_dl[i] <= b_dl[i-1];
               end
            end
         end

         assign a_seg = a_dl[k-1];
         assign b_seg = b_dl[k-1];
         assign c_in  = carry_w[k-1];
      end

      assign sum = {1'b0, a_seg} + {1'b0, b_seg} + {{CW{1'b0}}, c_in};

      always_ff @(posedge clk) begin
         if (rst) begin
            carry_q <= 1'b0;
            for (int i = 0; i < STAGES - k; i++) r_dl[i] <= '0;
         end else if (bus.en) begin
            carry_q <= sum[CW];
            r_dl[0] <= sum[CW-1:0];
            for (int i = 1; i < STAGES - k; i++) r_dl[i] <= r_dl[i-1];
         end
      end

      assign carry_w[k]     = carry_q;
      assign s_w[LO +: CW]  = r_dl[STAGES-k-1];

      if (k == STAGES - 1) begin : g_top
         logic ovf_q;
         logic msb_cin;
         // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
         assign msb_cin = a_seg[CW-1] ^ b_seg[CW-1] ^ sum[CW-1];

         always_ff @(posedge clk) begin
            if (rst) begin
               ovf_q <= 1'b0;
            end else if (bus.en) begin
               ovf_q <= msb_cin ^ sum[CW];
            end
         end

         assign ovf_w = ovf_q;
      end
   end

   assign bus.out_valid = v_q[STAGES-1];
   assign bus.s         = s_w;
   assign bus.cout      = carry_w[STAGES-1];
   assign bus.ovf       = ovf_w;
endmodule
